// File: rtl/ux607_icache_ram_ctrl.sv
// ux607_icache_ram_ctrl: sequencer/arbiter in front of one icache RAM array.
// After reset (and on flush_req) it sweeps every entry to zero, then shares
// the single RAM port between fetch reads and refill writes. Refill has
// priority, bounded by STARVE_MAX consecutive refill wins while a fetch waits.
// Optional light-sleep support is enabled with `define UX607_ICACHE_RAM_LS_EN.
module ux607_icache_ram_ctrl #(
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int MW         = 4,
  parameter int DP         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_req,
  output logic          flush_busy,
  output logic          init_done,
  input  logic          fch_req,
  input  logic [AW-1:0] fch_addr,
  output logic          fch_gnt,
  output logic          fch_rvalid,
  output logic [DW-1:0] fch_rdata,
  input  logic          rfl_req,
  input  logic [AW-1:0] rfl_addr,
  input  logic [MW-1:0] rfl_wem,
  input  logic [DW-1:0] rfl_din,
  output logic          rfl_gnt,
  output logic          ram_cs,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_ls
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {SWEEP, IDLE} state_t;

  state_t        state;
  logic [AW:0]   cnt;      // one spare bit so DP-1 is never confused with a wrap
  logic [SW-1:0] starve;
  logic          rfl_win;
  logic          in_idle;

  assign in_idle = (state == IDLE);

  // Refill normally wins; a fetch that has waited STARVE_MAX refill grants wins once.
  assign rfl_win = rfl_req && !(fch_req && (starve == SW'(STARVE_MAX)));
  assign rfl_gnt = in_idle && rfl_win;
  assign fch_gnt = in_idle && fch_req && !rfl_win;

  // Read data comes straight from the RAM; it is meaningful only with fch_rvalid.
  assign fch_rdata = ram_dout;

  // Drive the RAM port from the sweep or from whichever requester was granted.
  always_comb begin
    ram_cs   = 1'b0;
    ram_addr = '0;
    ram_wem  = '0;
    ram_din  = '0;
    if (state == SWEEP) begin
      ram_cs   = 1'b1;
      ram_addr = cnt[AW-1:0];
      ram_wem  = '1;
      ram_din  = '0;
    end else if (rfl_gnt) begin
      ram_cs   = 1'b1;
      ram_addr = rfl_addr;
      ram_wem  = rfl_wem;
      ram_din  = rfl_din;
    end else if (fch_gnt) begin
      ram_cs   = 1'b1;
      ram_addr = fch_addr;
    end
  end

  // Sweep/idle sequencer; a flush only restarts the sweep from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SWEEP;
      cnt        <= '0;
      flush_busy <= 1'b1;
      init_done  <= 1'b0;
    end else begin
      case (state)
        SWEEP: begin
          if (cnt == (AW+1)'(DP - 1)) begin
            state      <= IDLE;
            cnt        <= '0;
            flush_busy <= 1'b0;
            init_done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (flush_req) begin
            state      <= SWEEP;
            cnt        <= '0;
            flush_busy <= 1'b1;
          end
        end
      endcase
    end
  end

  // Read data is valid exactly one cycle after a fetch grant, whatever the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fch_rvalid <= 1'b0;
    end else begin
      fch_rvalid <= fch_gnt;
    end
  end

  // Count refill wins against a waiting fetch; saturate so the fetch keeps its turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve <= '0;
    end else if (!fch_req || fch_gnt) begin
      starve <= '0;
    end else if (rfl_gnt && (starve != SW'(STARVE_MAX))) begin
      starve <= starve + 1'b1;
    end
  end

`ifdef UX607_ICACHE_RAM_LS_EN
  logic [3:0] idle_cnt;
  logic       any_req;

  assign any_req = fch_req || rfl_req || flush_req;
  // Any request wakes the RAM in the same cycle so the access is not delayed.
  assign ram_ls  = in_idle && (idle_cnt == 4'd15) && !any_req;

  // Count quiet IDLE cycles (no request means no chip select), saturating at 15.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (!in_idle || any_req) begin
      idle_cnt <= '0;
    end else if (idle_cnt != 4'd15) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign ram_ls = 1'b0;
`endif

endmodule

// File: tb/tb_ux607_icache_ram_ctrl.sv
// Self-checking bench for ux607_icache_ram_ctrl: a behavioural RAM, a
// table of directed vectors, hand sequences for flush/reset corners and a
// randomized run checked against a cycle-level reference model.
module tb_ux607_icache_ram_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int DP = 32;
  localparam int SM = 4;

  logic          clk, rst_n;
  logic          flush_req, flush_busy, init_done;
  logic          fch_req, fch_gnt, fch_rvalid;
  logic [AW-1:0] fch_addr;
  logic [DW-1:0] fch_rdata;
  logic          rfl_req, rfl_gnt;
  logic [AW-1:0] rfl_addr;
  logic [MW-1:0] rfl_wem;
  logic [DW-1:0] rfl_din;
  logic          ram_cs, ram_ls;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_wem;
  logic [DW-1:0] ram_din, ram_dout;

  ux607_icache_ram_ctrl #(.AW(AW), .DW(DW), .MW(MW), .DP(DP), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .flush_busy(flush_busy),
    .init_done(init_done), .fch_req(fch_req), .fch_addr(fch_addr), .fch_gnt(fch_gnt),
    .fch_rvalid(fch_rvalid), .fch_rdata(fch_rdata), .rfl_req(rfl_req), .rfl_addr(rfl_addr),
    .rfl_wem(rfl_wem), .rfl_din(rfl_din), .rfl_gnt(rfl_gnt), .ram_cs(ram_cs),
    .ram_addr(ram_addr), .ram_wem(ram_wem), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_ls(ram_ls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with byte masks and registered read
  logic [DW-1:0] mem [DP];
  initial ram_dout = '0;
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_wem != '0) begin
        for (int b = 0; b < MW; b++)
          if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit            m_sweep;
  int            m_idx;
  bit            m_init;
  int            m_starve;
  bit            m_rv;
  logic [DW-1:0] m_rd;
  logic [DW-1:0] shadow [DP];
  int            m_quiet;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sweep = 1; m_idx = 0; m_init = 0; m_starve = 0; m_rv = 0; m_quiet = 0;
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance model after posedge
  task automatic cycle(input bit f, input bit r, input bit fl,
                       input logic [AW-1:0] fa, input logic [AW-1:0] ra,
                       input logic [MW-1:0] wem, input logic [DW-1:0] din,
                       output bit g_f, output bit g_r, output bit rv, output logic [DW-1:0] rd);
    bit e_rw, e_fw, e_cs, e_ls;
    logic [AW-1:0] e_addr;
    logic [MW-1:0] e_wem;
    logic [DW-1:0] e_din;
    fch_req = f; rfl_req = r; flush_req = fl;
    fch_addr = fa; rfl_addr = ra; rfl_wem = wem; rfl_din = din;
    @(negedge clk);
    e_rw = !m_sweep && r && !(f && m_starve == SM);
    e_fw = !m_sweep && f && !e_rw;
    e_cs = 0; e_addr = '0; e_wem = '0; e_din = '0;
    if (m_sweep) begin e_cs = 1; e_addr = AW'(m_idx); e_wem = '1; end
    else if (e_rw) begin e_cs = 1; e_addr = ra; e_wem = wem; e_din = din; end
    else if (e_fw) begin e_cs = 1; e_addr = fa; end
`ifdef UX607_ICACHE_RAM_LS_EN
    e_ls = !m_sweep && !(f || r || fl) && (m_quiet >= 15);
`else
    e_ls = 0;
`endif
    chk("fch_gnt", 64'(fch_gnt), 64'(e_fw));
    chk("rfl_gnt", 64'(rfl_gnt), 64'(e_rw));
    chk("ram_cs", 64'(ram_cs), 64'(e_cs));
    chk("ram_addr", 64'(ram_addr), 64'(e_addr));
    chk("ram_wem", 64'(ram_wem), 64'(e_wem));
    if (!e_fw) chk("ram_din", 64'(ram_din), 64'(e_din));
    chk("flush_busy", 64'(flush_busy), 64'(m_sweep));
    chk("init_done", 64'(init_done), 64'(m_init));
    chk("fch_rvalid", 64'(fch_rvalid), 64'(m_rv));
    if (m_rv) chk("fch_rdata", 64'(fch_rdata), 64'(m_rd));
    chk("ram_ls", 64'(ram_ls), 64'(e_ls));
    g_f = fch_gnt; g_r = rfl_gnt; rv = fch_rvalid; rd = fch_rdata;
    @(posedge clk); #1;
    m_rv = e_fw;
    if (e_fw) m_rd = shadow[fa];
    if (e_rw)
      for (int b = 0; b < MW; b++)
        if (wem[b]) shadow[ra][b*8 +: 8] = din[b*8 +: 8];
    if (!f || e_fw) m_starve = 0;
    else if (e_rw && m_starve < SM) m_starve++;
    m_quiet = (m_sweep || f || r || fl) ? 0 : m_quiet + 1;
    if (m_sweep) begin
      shadow[m_idx] = '0;
      m_idx++;
      if (m_idx == DP) begin m_sweep = 0; m_idx = 0; m_init = 1; end
    end else if (fl) begin
      m_sweep = 1; m_idx = 0;
    end
  endtask

  typedef struct {
    bit f; bit r; logic [AW-1:0] fa; logic [AW-1:0] ra; logic [MW-1:0] wem;
    logic [DW-1:0] din; bit exp_f; bit exp_r; bit chk_rd; logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t tbl [19];
  bit gf, gr, rv;
  logic [DW-1:0] rd;

  initial begin
    // Directed table: write/read-back, starvation pattern, partial-mask write
    tbl[0]  = '{0,0,0,0,0,0,0,0,0,0};
    tbl[1]  = '{0,1,0,5,4'hF,32'hDEADBEEF,0,1,0,0};
    tbl[2]  = '{1,0,5,0,0,0,1,0,0,0};
    tbl[3]  = '{0,0,0,0,0,0,0,0,1,32'hDEADBEEF};
    for (int i = 0; i < 10; i++)
      tbl[4+i] = '{1,1,5,9,4'h3,32'h0000A5A5,(i%5)==4,(i%5)!=4,0,0};
    tbl[14] = '{0,1,0,5,4'h1,32'h11223344,0,1,0,0};
    tbl[15] = '{1,0,5,0,0,0,1,0,0,0};
    tbl[16] = '{0,0,0,0,0,0,0,0,1,32'hDEADBE44};
    tbl[17] = '{1,0,9,0,0,0,1,0,0,0};
    tbl[18] = '{0,0,0,0,0,0,0,0,1,32'h0000A5A5};

    rst_n = 0; fch_req = 0; rfl_req = 0; flush_req = 0;
    fch_addr = '0; rfl_addr = '0; rfl_wem = '0; rfl_din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Post-reset sweep, then first idle cycle
    repeat (DP + 1) cycle(0, 0, 0, 0, 0, 0, 0, gf, gr, rv, rd);

    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].f, tbl[i].r, 0, tbl[i].fa, tbl[i].ra, tbl[i].wem, tbl[i].din, gf, gr, rv, rd);
      chk($sformatf("tbl%0d_fgnt", i), 64'(gf), 64'(tbl[i].exp_f));
      chk($sformatf("tbl%0d_rgnt", i), 64'(gr), 64'(tbl[i].exp_r));
      if (tbl[i].chk_rd) begin
        chk($sformatf("tbl%0d_rv", i), 64'(rv), 64'(1));
        chk($sformatf("tbl%0d_rd", i), 64'(rd), 64'(tbl[i].exp_rd));
      end
    end

    // Flush while a fetch is granted: rvalid still delivered, then a full sweep
    cycle(1, 0, 1, 5, 0, 0, 0, gf, gr, rv, rd);
    chk("flush_fetch_gnt", 64'(gf), 64'(1));
    cycle(1, 1, 0, 5, 3, 4'hF, 32'h1, gf, gr, rv, rd);
    chk("flush_fetch_rv", 64'(rv), 64'(1));
    chk("flush_fetch_rd", 64'(rd), 64'(32'hDEADBE44));
    for (int i = 1; i < DP; i++)
      cycle(1, 1, i == 10, 5, 3, 4'hF, 32'h1, gf, gr, rv, rd);
    cycle(0, 0, 0, 0, 0, 0, 0, gf, gr, rv, rd);

    // Reset asserted while the sweep is at address 17
    cycle(0, 0, 1, 0, 0, 0, 0, gf, gr, rv, rd);
    repeat (17) cycle(0, 0, 0, 0, 0, 0, 0, gf, gr, rv, rd);
    chk("sweep_at_17", 64'(ram_addr), 64'(17));
    rst_n = 0;
    #1;
    chk("rst_init_done", 64'(init_done), 64'(0));
    chk("rst_flush_busy", 64'(flush_busy), 64'(1));
    chk("rst_ram_addr", 64'(ram_addr), 64'(0));
    chk("rst_rvalid", 64'(fch_rvalid), 64'(0));
    chk("rst_ls", 64'(ram_ls), 64'(0));
    model_reset();
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1;
    repeat (DP + 1) cycle(0, 0, 0, 0, 0, 0, 0, gf, gr, rv, rd);

    // Quiet idle stretch then a fetch (light-sleep entry and wake when enabled)
    repeat (16) cycle(0, 0, 0, 0, 0, 0, 0, gf, gr, rv, rd);
    cycle(1, 0, 0, 7, 0, 0, 0, gf, gr, rv, rd);
    chk("wake_fgnt", 64'(gf), 64'(1));

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 2,
            AW'($urandom), AW'($urandom_range(0, 7)), MW'($urandom), $urandom,
            gf, gr, rv, rd);
      if (gf && gr) chk("both_gnt", 64'(1), 64'(0));
      if ((i % 300) == 299) repeat (18) cycle(0, 0, 0, 0, 0, 0, 0, gf, gr, rv, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
